// File: rtl/hxd32_ifu_pkg.sv
// Shared types and helpers for the instruction prefetch unit.
package hxd32_ifu_pkg;

  localparam int IFU_XLEN = 32;

  // Major opcode of JAL; predecoded in the prefetcher to redirect early.
  localparam logic [6:0] OPCODE_JAL = 7'b1101111;

  // One buffered fetch: the word and the address it was fetched from.
  typedef struct packed {
    logic [IFU_XLEN-1:0] pc;
    logic [IFU_XLEN-1:0] inst;
  } fetch_entry_t;

  // Raw 21-bit J-type immediate (bit 0 always zero); caller sign-extends.
  function automatic logic [20:0] j_imm(input logic [31:0] inst);
    return {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Show-ahead synchronous FIFO with flush; head entry is visible while non-empty.
module ifu_fifo
  import hxd32_ifu_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  entry_t                 push_data,
  input  logic                   pop,
  output entry_t                 head_data,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          full;
  logic          do_push;
  logic          do_pop;
  entry_t        slots [DEPTH];

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (AW+1)'(DEPTH));
  // Flush overrides both ports; guards keep pointers consistent at the limits.
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign count   = count_reg;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      entry_t slot_reg;

      // Storage slot: written only when the write pointer selects it.
      always_ff @(posedge clk) begin
        if (do_push && (wr_ptr_reg == AW'(gi))) begin
          slot_reg <= push_data;
        end
      end

      assign slots[gi] = slot_reg;
    end
  endgenerate

  assign head_data = slots[rd_ptr_reg];

  // Pointer and occupancy bookkeeping; flush empties in one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/ifu_pf.sv
// Instruction prefetcher: sequential IRAM fetch with credit flow control,
// execute-stage redirect and optional JAL predecode redirect.
module ifu_pf
  import hxd32_ifu_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              DEPTH       = 4,
  parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
  parameter int              JAL_PREDICT = 1
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            redir_en_i,
  input  logic [XLEN-1:0] redir_pc_i,
  output logic            iram_rd_en_o,
  output logic [XLEN-1:0] iram_rd_addr_o,
  input  logic [XLEN-1:0] iram_rd_data_i,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  output logic [XLEN-1:0] inst_data_o,
  output logic [XLEN-1:0] inst_pc_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  // Entry type sized by XLEN so the buffer follows the datapath width.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } entry_t;

  logic            run_reg;
  logic [XLEN-1:0] fetch_pc_reg;
  logic [XLEN-1:0] fetch_pc_next;
  logic            inflight_reg;
  logic            inflight_next;
  logic [XLEN-1:0] inflight_pc_reg;

  logic [CW-1:0]   fifo_count;
  logic            fifo_empty;
  logic [CW:0]     credit_used;
  logic            issue;
  logic            push;
  logic            pop;
  logic            jal_hit;
  logic [20:0]     jal_imm;
  logic [XLEN-1:0] jal_target;
  entry_t          push_entry;
  entry_t          head_entry;
  logic            unused_redir_lsb;

  assign unused_redir_lsb = ^redir_pc_i[1:0];

  // Credit counts buffered entries plus the one response still on the bus,
  // so every issued request is guaranteed a slot when it returns.
  assign credit_used = (CW+1)'(fifo_count) + (CW+1)'(inflight_reg);
  assign issue       = run_reg & ~redir_en_i & (credit_used < (CW+1)'(DEPTH));

  // A live response is pushed unless a redirect flushes it this cycle.
  assign push        = inflight_reg & ~redir_en_i;
  assign pop         = inst_valid_o & inst_ready_i & ~redir_en_i;

  assign jal_imm     = j_imm(iram_rd_data_i[31:0]);
  assign jal_target  = inflight_pc_reg + {{(XLEN-21){jal_imm[20]}}, jal_imm};
  assign jal_hit     = (JAL_PREDICT != 0) & push & (iram_rd_data_i[6:0] == OPCODE_JAL);

  assign push_entry.pc   = inflight_pc_reg;
  assign push_entry.inst = iram_rd_data_i;

  // Request issued alongside a JAL push fetches the fall-through path: drop it.
  assign inflight_next = issue & ~jal_hit;

  // Next fetch address: redirect beats JAL predecode beats sequential advance.
  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    if (redir_en_i) begin
      fetch_pc_next = {redir_pc_i[XLEN-1:2], 2'b00};
    end else if (jal_hit) begin
      fetch_pc_next = jal_target;
    end else if (issue) begin
      fetch_pc_next = fetch_pc_reg + XLEN'(4);
    end
  end

  // Run flag: fetching begins one edge after reset release.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      run_reg <= 1'b0;
    end else begin
      run_reg <= 1'b1;
    end
  end

  // Fetch PC register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fetch_pc_reg <= RESET_PC;
    end else begin
      fetch_pc_reg <= fetch_pc_next;
    end
  end

  // In-flight request tracking: remembers the PC of the word due next cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      inflight_reg    <= 1'b0;
      inflight_pc_reg <= '0;
    end else begin
      inflight_reg <= inflight_next;
      if (issue) begin
        inflight_pc_reg <= fetch_pc_reg;
      end
    end
  end

  ifu_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk_i),
    .rst_n     (rst_n_i),
    .flush     (redir_en_i),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head_entry),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign iram_rd_en_o   = issue;
  assign iram_rd_addr_o = fetch_pc_reg;
  assign inst_valid_o   = ~fifo_empty;
  // Slot storage is not reset, so outputs are forced to zero while empty.
  assign inst_data_o    = fifo_empty ? '0 : head_entry.inst;
  assign inst_pc_o      = fifo_empty ? '0 : head_entry.pc;

endmodule

// File: tb/tb_ifu_pf.sv
// Scoreboard bench for ifu_pf: a program-order model of the instruction
// stream is checked against every head presented to decode.
module tb_ifu_pf;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redir_en = 1'b0;
  logic [31:0] redir_pc = 32'h0;
  logic        iram_rd_en;
  logic [31:0] iram_rd_addr;
  logic [31:0] iram_rd_data;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          mem_mode = 0;
  logic [31:0] mem_seed = 32'h0;

  logic [31:0] issued_addrs[$];
  logic [31:0] popped_pcs[$];
  logic [31:0] exp_pc[$];
  logic [31:0] gen_pc;

  always #5 clk = ~clk;

  ifu_pf #(
    .XLEN        (32),
    .DEPTH       (4),
    .RESET_PC    (RESET_PC),
    .JAL_PREDICT (1)
  ) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .redir_en_i     (redir_en),
    .redir_pc_i     (redir_pc),
    .iram_rd_en_o   (iram_rd_en),
    .iram_rd_addr_o (iram_rd_addr),
    .iram_rd_data_i (iram_rd_data),
    .inst_valid_o   (inst_valid),
    .inst_ready_i   (inst_ready),
    .inst_data_o    (inst_data),
    .inst_pc_o      (inst_pc)
  );

  // ---------------- program image (pure function of address) ----------------
  function automatic logic [31:0] hash32(input logic [31:0] a);
    logic [31:0] h;
    h = (a * 32'h9E3779B1) ^ mem_seed;
    h = h ^ (h >> 15);
    h = h * 32'h85EBCA6B;
    h = h ^ (h >> 13);
    return h;
  endfunction

  function automatic bit is_jal(input logic [31:0] a);
    logic [31:0] h;
    h = hash32(a);
    case (mem_mode)
      1:       return (a == 32'h4);
      2:       return (h[2:0] == 3'd0);
      default: return 1'b0;
    endcase
  endfunction

  function automatic int jal_off(input logic [31:0] a);
    logic [31:0] h;
    int off;
    if (mem_mode == 1) return 16;
    h = hash32(a);
    off = ((int'(h[15:8]) % 24) - 8) * 4;
    if (off == 0) off = 8;
    return off;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] h;
    logic [20:0] im;
    int off;
    if (mem_mode == 1 && a == 32'h4) return 32'h0100_026F;
    h = hash32(a);
    if (is_jal(a)) begin
      off = jal_off(a);
      im  = off[20:0];
      return {im[20], im[10:1], im[11], im[19:12], h[11:7], 7'b1101111};
    end
    return {h[31:7], 7'b0010011};
  endfunction

  // Program order: a JAL continues at pc+offset, anything else at pc+4.
  function automatic logic [31:0] next_pc(input logic [31:0] a);
    if (is_jal(a)) return a + 32'(jal_off(a));
    return a + 32'd4;
  endfunction

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // IRAM: one-cycle read latency; logs every request address.
  always @(posedge clk) begin
    if (iram_rd_en) begin
      iram_rd_data <= mem_word(iram_rd_addr);
      issued_addrs.push_back(iram_rd_addr);
    end
  end

  // Monitor + scoreboard: restart the expected stream on reset/redirect,
  // otherwise compare every presented head and retire it on acceptance.
  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_pc.delete();
        gen_pc = RESET_PC;
        check("reset_valid", 32'(inst_valid), 32'd0);
        check("reset_rd_en", 32'(iram_rd_en), 32'd0);
        check("reset_addr", iram_rd_addr, RESET_PC);
        check("reset_pc", inst_pc, 32'd0);
        check("reset_data", inst_data, 32'd0);
      end else if (redir_en) begin
        exp_pc.delete();
        gen_pc = {redir_pc[31:2], 2'b00};
      end else begin
        while (exp_pc.size() < 8) begin
          exp_pc.push_back(gen_pc);
          gen_pc = next_pc(gen_pc);
        end
        if (inst_valid) begin
          check("head_pc", inst_pc, exp_pc[0]);
          check("head_data", inst_data, mem_word(exp_pc[0]));
          if (inst_ready) begin
            $display("pop pc=%h inst=%h", inst_pc, inst_data);
            popped_pcs.push_back(inst_pc);
            void'(exp_pc.pop_front());
          end
        end
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle reset pulse starting just after an edge; outputs must drop at once.
  task automatic pulse_reset(input int mode, input logic ready);
    rst_n      = 1'b0;
    mem_mode   = mode;
    inst_ready = ready;
    redir_en   = 1'b0;
    #1;
    check("async_reset_valid", 32'(inst_valid), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  int mi, mp, k;

  initial begin
    fork
      monitor_loop();
    join_none

    // Reset values and first-request latency, sequential stream.
    cyc(3);
    check("rst_rd_en", 32'(iram_rd_en), 32'd0);
    check("rst_addr", iram_rd_addr, RESET_PC);
    rst_n = 1'b1;
    mi = issued_addrs.size();
    cyc(1);
    check("first_req_en", 32'(iram_rd_en), 32'd1);
    check("first_req_addr", iram_rd_addr, RESET_PC);
    check("lat_cycle_n", 32'(inst_valid), 32'd0);
    cyc(1);
    check("lat_cycle_n1", 32'(inst_valid), 32'd0);
    cyc(1);
    check("lat_cycle_n2", 32'(inst_valid), 32'd1);
    check("b2b_pc0", inst_pc, 32'h0);
    cyc(1);
    check("b2b_pc4", inst_pc, 32'h4);
    cyc(1);
    check("b2b_pc8", inst_pc, 32'h8);
    check("addr_seq0", qget(issued_addrs, mi), 32'h0);
    check("addr_seq1", qget(issued_addrs, mi + 1), 32'h4);
    check("addr_seq2", qget(issued_addrs, mi + 2), 32'h8);

    // Reset mid-stream: immediate invalidation, refetch from RESET_PC.
    cyc(5);
    pulse_reset(0, 1'b1);
    mi = issued_addrs.size();
    cyc(6);
    check("refetch_addr", qget(issued_addrs, mi), RESET_PC);

    // Decode stalled: credit limits outstanding fetches to DEPTH.
    cyc(2);
    pulse_reset(0, 1'b0);
    mi = issued_addrs.size();
    cyc(12);
    check("stall_req_count", 32'(issued_addrs.size() - mi), 32'd4);
    check("stall_rd_en", 32'(iram_rd_en), 32'd0);
    check("stall_valid", 32'(inst_valid), 32'd1);
    check("stall_pc_held", inst_pc, 32'h0);
    mp = popped_pcs.size();
    inst_ready = 1'b1;
    cyc(12);
    check("resume_pop0", qget(popped_pcs, mp), 32'h0);
    check("resume_pop4", qget(popped_pcs, mp + 4), 32'h10);

    // Redirect while full with ready high: flush, resume at aligned target.
    pulse_reset(0, 1'b0);
    cyc(10);
    inst_ready = 1'b1;
    redir_en   = 1'b1;
    redir_pc   = 32'h0000_0103;
    cyc(1);
    redir_en = 1'b0;
    check("flush_empty", 32'(inst_valid), 32'd0);
    k = 0;
    while (!inst_valid && k < 10) begin
      cyc(1);
      k++;
    end
    check("redir_wait_valid", 32'(inst_valid), 32'd1);
    check("redir_first_pc", inst_pc, 32'h100);

    // JAL predecode: 0x4 holds jal +16.
    cyc(3);
    pulse_reset(1, 1'b1);
    mi = issued_addrs.size();
    mp = popped_pcs.size();
    cyc(12);
    check("jal_pop0", qget(popped_pcs, mp), 32'h0);
    check("jal_pop1", qget(popped_pcs, mp + 1), 32'h4);
    check("jal_pop2", qget(popped_pcs, mp + 2), 32'h14);
    check("jal_killed_req", qget(issued_addrs, mi + 2), 32'h8);
    check("jal_next_fetch", qget(issued_addrs, mi + 3), 32'h14);

    // Redirect coincident with the JAL push: redirect wins, JAL entry dropped.
    pulse_reset(1, 1'b1);
    cyc(3);
    check("jal_push_cycle_addr", iram_rd_addr, 32'h8);
    redir_en = 1'b1;
    redir_pc = 32'h0000_0200;
    mp = popped_pcs.size();
    cyc(1);
    redir_en = 1'b0;
    cyc(10);
    check("redir_jal_pop0", qget(popped_pcs, mp), 32'h200);
    check("redir_jal_pop1", qget(popped_pcs, mp + 1), 32'h204);

    // Randomised traffic: random stalls, redirects and occasional resets.
    mem_seed = $urandom;
    pulse_reset(2, 1'b1);
    mp = popped_pcs.size();
    for (int i = 0; i < 2500; i++) begin
      inst_ready = ($urandom_range(0, 3) != 0);
      if (redir_en) begin
        redir_en = 1'b0;
      end else if ($urandom_range(0, 39) == 0) begin
        redir_en = 1'b1;
        redir_pc = 32'($urandom_range(0, 4095));
      end
      if ($urandom_range(0, 599) == 0) begin
        pulse_reset(2, 1'b1);
      end else begin
        cyc(1);
      end
    end
    redir_en   = 1'b0;
    inst_ready = 1'b1;
    cyc(5);
    check("random_progress", 32'(popped_pcs.size() - mp > 500), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ifu_pf.md
IFU_PF -- requirements
Module: ifu_pf

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data/address width.
REQ-002 SHALL have parameter DEPTH, default 4, meaning prefetch entries; power of two, >=2.
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address.
REQ-004 SHALL have parameter JAL_PREDICT, default 1, meaning 1 enables JAL predecode redirect.
REQ-005 SHALL have port clk_i  input  1  the single clock, rising-edge.
REQ-006 SHALL have port rst_n_i  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port redir_en_i  input  1  execute-stage redirect (branch/jalr/trap).
REQ-008 SHALL have port redir_pc_i  input  XLEN  redirect target; bits [1:0] ignored.
REQ-009 SHALL have port iram_rd_en_o  output  1  IRAM read request.
REQ-010 SHALL have port iram_rd_addr_o  output  XLEN  IRAM byte address.
REQ-011 SHALL have port iram_rd_data_i  input  XLEN  IRAM data, valid one cycle after request.
REQ-012 SHALL have port inst_valid_o  output  1  head entry valid to decode.
REQ-013 SHALL have port inst_ready_i  input  1  decode accepts head entry.
REQ-014 SHALL have port inst_data_o  output  XLEN  head instruction word.
REQ-015 SHALL have port inst_pc_o  output  XLEN  head instruction address.

Function
REQ-016 SHALL hold fetch_pc; iram_rd_addr_o = fetch_pc; fetch_pc += 4 on each issued request (modulo 2^XLEN wrap).
REQ-017 SHALL issue (iram_rd_en_o=1) only when run flag set, redir_en_i=0, and fifo_count + live_inflight < DEPTH.
REQ-018 SHALL capture iram_rd_data_i with the request's PC one cycle after a live request and push {pc, inst} into FIFO.
REQ-019 Latency: request in cycle N -> inst_valid_o=1 in cycle N+2; sustained throughput 1 inst/cycle with inst_ready_i=1.
REQ-020 SHALL pop head when inst_valid_o & inst_ready_i; push and pop in same cycle SHALL keep count; full FIFO never overflows, empty never underflows.
REQ-021 inst_valid_o = FIFO non-empty; inst_data_o/inst_pc_o SHALL hold stable while valid & !ready.
REQ-022 redir_en_i=1 SHALL, at that edge: flush FIFO, kill in-flight response, set fetch_pc = {redir_pc_i[XLEN-1:2],2'b00}; redirect beats push and pop in the same cycle (neither takes effect, including a pop with ready high).
REQ-023 With JAL_PREDICT=1, a pushed word with opcode 7'b1101111 SHALL set fetch_pc = pc + sext(J-imm) and kill the request issued in that same cycle; JAL entry itself is pushed.
REQ-024 If redir_en_i and a JAL push coincide, redirect SHALL win and the JAL push SHALL be dropped.
REQ-025 Killed responses SHALL never enter FIFO nor count toward credit.

Reset
REQ-026 While rst_n_i=0: fetch_pc=RESET_PC, FIFO empty, inflight cleared, run flag 0.
REQ-027 Reset output values: iram_rd_en_o=0, iram_rd_addr_o=RESET_PC, inst_valid_o=0, inst_data_o=0, inst_pc_o=0.
REQ-028 Run flag SHALL set on first rising edge after release; first request issues the following cycle.
REQ-029 Reset asserted mid-operation SHALL discard all entries and in-flight data immediately.

Structure
REQ-030 Package hxd32_ifu_pkg SHALL hold fetch_entry_t {pc, inst}, OPCODE_JAL, and J-immediate extraction function.
REQ-031 One sub-module ifu_fifo (synchronous FIFO with flush, parametrised DEPTH and entry type) SHALL implement buffering.

Verification
REQ-032 Reset release, ready=1, RESET_PC=0 -> addresses 0x0,0x4,0x8,... and inst_pc_o sequence 0x0,0x4,0x8 back-to-back.
REQ-033 ready=0, DEPTH=4 -> exactly 4 requests issued, iram_rd_en_o then 0, inst_pc_o held at 0x0; ready=1 resumes without loss.
REQ-034 Word 32'h0100026F at pc 0x4 -> next fetched address 0x14; inst_pc_o sequence 0x0,0x4,0x14; entry for pc 0x8 never presented.
REQ-035 redir_en_i=1, redir_pc_i=32'h0000_0103 while FIFO full and ready=1 -> no pop that cycle, FIFO empty next cycle, next inst_pc_o 0x100.
REQ-036 redir_en_i coincident with JAL push -> fetch resumes at redirect target, JAL entry absent.
REQ-037 rst_n_i low for 1 cycle mid-stream -> inst_valid_o=0 immediately, refetch starts at RESET_PC.
